// File: rtl/mdio_responder_if.sv
// Register-file side of the MDIO responder.
// master: responder (drives addr/wdata/strobes); slave: register file (drives rdata).
interface mdio_responder_if;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/mdio_responder.sv
// Clause 22 MDIO PHY-side responder, oversampled on clk_i.
// Ports: clk_i/rst_i, mdc_i/mdio_i in, mdio_o/mdio_oe out, frame_err pulse,
// regs (master): reg_addr, reg_wdata, reg_we, reg_re out; reg_rdata in.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter bit         BCAST_EN = 1'b0,
  parameter int         PRE_LEN  = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdio_o,
  output logic mdio_oe,
  output logic frame_err,
  mdio_responder_if.master regs
);

  typedef enum logic [3:0] {
    S_PRE,
    S_ST1,
    S_OP,
    S_ADDR,
    S_TA1,
    S_RDATA,
    S_WTA,
    S_WDATA,
    S_SKIP
  } state_t;

  localparam logic [5:0] PRE_MAX = 6'(PRE_LEN);

  logic mdc_s1_q, mdc_s2_q, mdc_s3_q;
  logic mdio_s1_q, mdio_s2_q;
  logic edge_q;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  pre_q, pre_d;
  logic [4:0]  phy_q, phy_d;
  logic        rd_q, rd_d;
  logic [15:0] sh_q, sh_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic        err_q, err_d;
  logic        oe_q, oe_d;
  logic        o_q, o_d;

  logic smp;
  logic match;

  assign smp = mdio_s2_q;
  // Broadcast PHYAD 0 only ever accepts writes.
  assign match = (phy_q == PHY_ADDR) ||
                 (BCAST_EN && (phy_q == 5'd0) && !rd_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    phy_d   = phy_q;
    rd_d    = rd_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    err_d   = 1'b0;
    oe_d    = oe_q;
    o_d     = o_q;

    // Read data arrives one clk after the read strobe.
    if (re_q) sh_d = regs.reg_rdata;

    if (edge_q) begin
      unique case (state_q)
        S_PRE: begin
          if (smp) begin
            if (pre_q < PRE_MAX) pre_d = pre_q + 6'd1;
          end else if (pre_q >= PRE_MAX) begin
            state_d = S_ST1;
            pre_d   = 6'd0;
          end else begin
            pre_d = 6'd0;
          end
        end
        S_ST1: begin
          if (smp) begin
            state_d = S_OP;
            cnt_d   = 5'd0;
          end else begin
            err_d   = 1'b1;
            state_d = S_PRE;
          end
        end
        S_OP: begin
          if (cnt_q == 5'd0) begin
            rd_d  = smp;
            cnt_d = 5'd1;
          end else if (rd_q != smp) begin
            state_d = S_ADDR;
            cnt_d   = 5'd0;
          end else begin
            err_d   = 1'b1;
            state_d = S_PRE;
          end
        end
        S_ADDR: begin
          if (cnt_q < 5'd5) phy_d = {phy_q[3:0], smp};
          else addr_d = {addr_q[3:0], smp};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd9) begin
            cnt_d = 5'd0;
            if (!match) begin
              state_d = S_SKIP;
            end else if (rd_q) begin
              re_d    = 1'b1;
              state_d = S_TA1;
            end else begin
              state_d = S_WTA;
            end
          end
        end
        S_TA1: begin
          oe_d    = 1'b1;
          o_d     = 1'b0;
          state_d = S_RDATA;
          cnt_d   = 5'd0;
        end
        S_RDATA: begin
          if (cnt_q == 5'd16) begin
            oe_d    = 1'b0;
            o_d     = 1'b0;
            state_d = S_PRE;
          end else begin
            o_d   = sh_q[15];
            sh_d  = {sh_q[14:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_WTA: begin
          if (smp != (cnt_q == 5'd0)) begin
            err_d   = 1'b1;
            state_d = S_PRE;
          end else if (cnt_q == 5'd0) begin
            cnt_d = 5'd1;
          end else begin
            state_d = S_WDATA;
            cnt_d   = 5'd0;
          end
        end
        S_WDATA: begin
          sh_d  = {sh_q[14:0], smp};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            wdata_d = sh_d;
            we_d    = 1'b1;
            state_d = S_PRE;
          end
        end
        S_SKIP: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd17) state_d = S_PRE;
        end
        default: begin
          state_d = S_PRE;
          pre_d   = 6'd0;
          oe_d    = 1'b0;
          o_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mdc_s1_q  <= 1'b0;
      mdc_s2_q  <= 1'b0;
      mdc_s3_q  <= 1'b0;
      mdio_s1_q <= 1'b0;
      mdio_s2_q <= 1'b0;
      edge_q    <= 1'b0;
      state_q   <= S_PRE;
      cnt_q     <= 5'd0;
      pre_q     <= 6'd0;
      phy_q     <= 5'd0;
      rd_q      <= 1'b0;
      sh_q      <= 16'd0;
      addr_q    <= 5'd0;
      wdata_q   <= 16'd0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      err_q     <= 1'b0;
      oe_q      <= 1'b0;
      o_q       <= 1'b0;
    end else begin
      mdc_s1_q  <= mdc_i;
      mdc_s2_q  <= mdc_s1_q;
      mdc_s3_q  <= mdc_s2_q;
      mdio_s1_q <= mdio_i;
      mdio_s2_q <= mdio_s1_q;
      edge_q    <= mdc_s2_q & ~mdc_s3_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      phy_q     <= phy_d;
      rd_q      <= rd_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      err_q     <= err_d;
      oe_q      <= oe_d;
      o_q       <= o_d;
    end
  end

  assign mdio_o         = o_q;
  assign mdio_oe        = oe_q;
  assign frame_err      = err_q;
  assign regs.reg_addr  = addr_q;
  assign regs.reg_wdata = wdata_q;
  assign regs.reg_we    = we_q;
  assign regs.reg_re    = re_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: table of frames plus reset-during-read sequence.
// Strobes are checked by a monitor against a queue of expected accesses.
module tb_mdio_responder;

  logic clk = 1'b0;
  logic rst_i;
  logic mdc_i;
  logic mdio_i;
  logic mdio_o;
  logic mdio_oe;
  logic frame_err;
  logic [15:0] rdata;

  mdio_responder_if regs_if ();
  assign regs_if.reg_rdata = rdata;

  mdio_responder dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .mdc_i     (mdc_i),
    .mdio_i    (mdio_i),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .frame_err (frame_err),
    .regs      (regs_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int          pre;
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  rega;
    logic [1:0]  ta;
    logic [15:0] data;
    bit          exp_strobe;
    bit          exp_err;
  } vec_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   err_cnt = 0;
  bit   oe_seen = 0;
  bit   o_bad   = 0;
  bit   both_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i) begin
      if (regs_if.reg_we && regs_if.reg_re) both_bad = 1;
      if (!mdio_oe && mdio_o) o_bad = 1;
      if (mdio_oe) oe_seen = 1;
      if (frame_err) err_cnt++;
      if (regs_if.reg_we || regs_if.reg_re) begin
        exp_t e;
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: we=%0b re=%0b addr=%0h, expected none",
                   regs_if.reg_we, regs_if.reg_re, regs_if.reg_addr);
        end else begin
          e = sbq.pop_front();
          if (regs_if.reg_we !== e.wr || regs_if.reg_addr !== e.addr ||
              (e.wr && regs_if.reg_wdata !== e.data)) begin
            n_fail++;
            $display("FAIL strobe: got we=%0b addr=%0h wdata=%0h, expected we=%0b addr=%0h wdata=%0h",
                     regs_if.reg_we, regs_if.reg_addr, regs_if.reg_wdata,
                     e.wr, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic mdc_bit(input logic b, output logic oe, output logic o);
    @(negedge clk);
    mdc_i  = 1'b0;
    mdio_i = b;
    repeat (5) @(negedge clk);
    mdc_i = 1'b1;
    repeat (5) @(negedge clk);
    oe = mdio_oe;
    o  = mdio_o;
  endtask

  task automatic send_hdr(input int pre, input logic [1:0] st,
                          input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] rega, output logic oe_last);
    logic oe, o;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, oe, o);
    for (int i = 1; i >= 0; i--) mdc_bit(st[i], oe, o);
    for (int i = 1; i >= 0; i--) mdc_bit(op[i], oe, o);
    for (int i = 4; i >= 0; i--) mdc_bit(phy[i], oe, o);
    for (int i = 4; i >= 0; i--) mdc_bit(rega[i], oe, o);
    oe_last = oe;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    logic oe, o, b, pre_oe;
    logic ta_oe, ta_o, rel_oe;
    logic [15:0] got;
    bit lost;
    bit is_rd;
    is_rd   = v.exp_strobe && (v.op == 2'b10);
    err_cnt = 0;
    oe_seen = 0;
    lost    = 0;
    got     = 16'd0;
    ta_oe   = 1'b0;
    ta_o    = 1'b1;
    rel_oe  = 1'b1;
    rdata   = v.data;
    if (v.exp_strobe)
      sbq.push_back('{wr: (v.op == 2'b01), addr: v.rega, data: v.data});
    send_hdr(v.pre, v.st, v.op, v.phy, v.rega, pre_oe);
    for (int i = 0; i < 18; i++) begin
      b = 1'b1;
      if (v.op == 2'b01) b = (i < 2) ? v.ta[1-i] : v.data[17-i];
      mdc_bit(b, oe, o);
      if (i == 0) begin
        ta_oe = oe;
        ta_o  = o;
      end else if (i <= 16) begin
        got[16-i] = o;
        if (!oe) lost = 1;
      end else begin
        rel_oe = oe;
      end
    end
    repeat (3) @(negedge clk);
    if (is_rd) begin
      chk({nm, "_ta1_oe"}, {31'd0, pre_oe}, 32'd0);
      chk({nm, "_ta2"}, {30'd0, ta_oe, ta_o}, 32'd2);
      chk({nm, "_rdata"}, {16'd0, got}, {16'd0, v.data});
      chk({nm, "_oe_held"}, {31'd0, lost}, 32'd0);
      chk({nm, "_release"}, {31'd0, rel_oe}, 32'd0);
    end else begin
      chk({nm, "_no_drive"}, {31'd0, oe_seen}, 32'd0);
    end
    chk({nm, "_frame_err"}, err_cnt, {31'd0, v.exp_err});
    chk({nm, "_pending"}, sbq.size(), 32'd0);
  endtask

  vec_t vecs[15];

  initial begin
    logic oe, o, dummy;
    vecs[0]  = '{32, 2'b01, 2'b01, 5'd1, 5'd4,  2'b10, 16'hBEEF, 1, 0};
    vecs[1]  = '{32, 2'b01, 2'b10, 5'd1, 5'd2,  2'b11, 16'h796D, 1, 0};
    vecs[2]  = '{32, 2'b01, 2'b10, 5'd3, 5'd2,  2'b11, 16'h1111, 0, 0};
    vecs[3]  = '{32, 2'b01, 2'b01, 5'd1, 5'd7,  2'b10, 16'h1234, 1, 0};
    vecs[4]  = '{31, 2'b01, 2'b01, 5'd1, 5'd5,  2'b10, 16'hBEEF, 0, 0};
    vecs[5]  = '{40, 2'b01, 2'b01, 5'd1, 5'd5,  2'b10, 16'h0F0F, 1, 0};
    vecs[6]  = '{32, 2'b00, 2'b01, 5'd1, 5'd5,  2'b10, 16'h5555, 0, 1};
    vecs[7]  = '{32, 2'b01, 2'b10, 5'd1, 5'd9,  2'b11, 16'hA5C3, 1, 0};
    vecs[8]  = '{32, 2'b01, 2'b11, 5'd1, 5'd9,  2'b10, 16'h2222, 0, 1};
    vecs[9]  = '{32, 2'b01, 2'b01, 5'd1, 5'd31, 2'b10, 16'h0001, 1, 0};
    vecs[10] = '{32, 2'b01, 2'b01, 5'd1, 5'd12, 2'b11, 16'h4321, 0, 1};
    vecs[11] = '{32, 2'b01, 2'b10, 5'd1, 5'd0,  2'b11, 16'hFFFF, 1, 0};
    vecs[12] = '{32, 2'b01, 2'b01, 5'd0, 5'd3,  2'b10, 16'h6666, 0, 0};
    vecs[13] = '{32, 2'b01, 2'b10, 5'd0, 5'd3,  2'b11, 16'h7777, 0, 0};
    vecs[14] = '{32, 2'b01, 2'b01, 5'd1, 5'd16, 2'b10, 16'h8000, 1, 0};

    rst_i  = 1'b1;
    mdc_i  = 1'b0;
    mdio_i = 1'b1;
    rdata  = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {5'd0, mdio_o, mdio_oe, frame_err, regs_if.reg_we, regs_if.reg_re,
         regs_if.reg_addr, regs_if.reg_wdata}, 32'd0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset asserted while data bit 7 of a read is on the pad.
    rdata = 16'h5A5A;
    sbq.push_back('{wr: 1'b0, addr: 5'd3, data: 16'h5A5A});
    send_hdr(32, 2'b01, 2'b10, 5'd1, 5'd3, dummy);
    for (int i = 0; i < 10; i++) mdc_bit(1'b1, oe, o);
    chk("mid_read_bit7", {30'd0, oe, o}, {30'd0, 1'b1, 1'b0});
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_async_oe", {31'd0, mdio_oe}, 32'd0);
    repeat (3) @(negedge clk);
    mdc_i = 1'b0;
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pending", sbq.size(), 32'd0);
    run_vec("post_rst_read",
            '{32, 2'b01, 2'b10, 5'd1, 5'd6, 2'b11, 16'h3C96, 1, 0});

    chk("oe0_implies_o0", {31'd0, o_bad}, 32'd0);
    chk("we_re_exclusive", {31'd0, both_bad}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- PHY-side MDIO (IEEE 802.3 Clause 22) management frame responder; the far end of the MAC's MDIO master.
- Oversamples MDC/MDIO on the system clock and decodes frames addressed to PHY_ADDR.
- Issues single-cycle register read/write strobes to a local register file and drives read data back onto MDIO.
- Used as the PHY model in MAC-level simulation and as the management front end of an FPGA-resident PHY shim.

Parameters:
- PHY_ADDR, 5'd1, PHY address this block answers to.
- BCAST_EN, 0, when 1 also answer writes to PHYAD 0; reads to PHYAD 0 are never answered.
- PRE_LEN, 32, minimum consecutive ones required before ST; range 1-32.

Ports:
- clk_i  input  1  system clock; also the only clock for this block.
- rst_i  input  1  asynchronous, active-high reset.
- mdc_i  input  1  MDC from the management master; asynchronous, must be at most clk_i/4.
- mdio_i  input  1  MDIO pad input; asynchronous.
- mdio_o  output  1  MDIO output value.
- mdio_oe  output  1  MDIO output enable; 1 means this block drives the pad.
- reg_addr  output  5  REGAD of the current frame.
- reg_wdata  output  16  write data, valid while reg_we=1.
- reg_we  output  1  one-clk_i write strobe.
- reg_re  output  1  one-clk_i read strobe.
- reg_rdata  input  16  read data; sampled exactly 1 clk_i after reg_re.
- frame_err  output  1  one-clk_i pulse on a malformed frame.

Behaviour:
- Reset: all outputs 0, state PRE, ones counter 0. rst_i asserted mid-frame releases mdio_oe asynchronously; any pending strobe is dropped.
- Synchronisation: mdc_i and mdio_i each pass through 2 flops. An MDC rising edge is registered when the synced MDC goes 0->1. All bit sampling and all mdio_o/mdio_oe updates happen in the clk_i cycle after that edge is detected.
- Preamble counter: counts consecutive sampled 1s, saturating at PRE_LEN.
- States and transitions:
  - PRE: sample 1 -> count++. Sample 0 with count>=PRE_LEN -> ST1. Sample 0 with count<PRE_LEN -> count=0, stay.
  - ST1: sample 1 -> OP. Sample 0 -> frame_err, PRE with count=0.
  - OP: 2 bits. 10=read, 01=write, 00/11 -> frame_err, PRE with count=0 (no reply).
  - PHYAD: 5 bits MSB first, then REGAD: 5 bits MSB first, loaded into reg_addr as shifted.
  - Address match: match = PHYAD==PHY_ADDR, or (BCAST_EN && PHYAD==0 && write).
  - On the sample of REGAD bit 0:
    - Matched read: reg_re=1 for one clk, enter TA1. reg_rdata is captured into the shift register on the next clk_i.
    - No match: enter SKIP with 18 bits remaining.
    - Matched write: enter WTA.
  - TA1 (read): mdio_oe stays 0. On the next edge -> mdio_oe=1, mdio_o=0 (TA2).
  - RDATA: on each following edge, drive the next data bit, bit 15 first, 16 bits. On the edge after bit 0 is driven -> mdio_oe=0, PRE with count=0.
  - WTA: 2 bits, must be 1 then 0. Mismatch -> frame_err, PRE with count=0.
  - WDATA: shift 16 bits MSB first. On the 16th sample, reg_wdata=data and reg_we=1 for one clk, then PRE with count=0.
  - SKIP: consume 18 samples without driving, then PRE with count=0.
- Strobes: reg_re and reg_we are never high together. reg_addr is stable from the strobe until the next frame's REGAD shifting begins.
- Minimum frame spacing: none beyond the preamble rule. Back-to-back frames with exactly PRE_LEN ones are accepted.
- mdio_o is 0 whenever mdio_oe=0.

Test Plan:
- Write: 32 ones, 01 01 00001 00100 10, data 0xBEEF -> exactly one reg_we pulse with reg_addr=4, reg_wdata=0xBEEF. mdio_oe stays 0 throughout.
- Read: 32 ones, 01 10 00001 00010, reg_rdata=0x796D -> one reg_re with reg_addr=2. mdio_oe=0 during TA1; mdio_o=0 during TA2; then 0x796D MSB first on 16 edges; mdio_oe=0 after the last bit.
- Wrong PHYAD=3: read -> no reg_re, mdio_oe never 1; the next valid frame is decoded correctly.
- Short preamble of 31 ones before a write -> no reg_we, no frame_err. Preamble of 40 ones -> accepted.
- Errors, each with a following good frame decoded:
  - ST=00 -> frame_err.
  - OP=11 -> frame_err.
  - Write TA=11 -> frame_err, no reg_we.
- rst_i pulsed during read data bit 7 -> mdio_oe=0 within the same clk. A subsequent full read returns correct data.
